// File: rtl/linearb_deadlock_watchdog.sv
// Deadlock watchdog for the lineArb HLS core: qualifies monitor block flags against a
// persistence threshold and latches a sticky report with a valid/ready handshake and IRQ.
module linearb_deadlock_watchdog #(
  parameter int NUM_MON = 4,
  parameter int IDX_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               enable,
  input  logic [CNT_W-1:0]   threshold,
  input  logic               clear,
  output logic               report_valid,
  input  logic               report_ready,
  output logic [IDX_W-1:0]   report_idx,
  output logic [NUM_MON-1:0] report_mask,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic               deadlock_irq,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COUNT   = 2'd1,
    S_REPORT  = 2'd2,
    S_LATCHED = 2'd3
  } state_t;

  state_t             state_reg;
  logic               valid_reg;
  logic               irq_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [NUM_MON-1:0] mask_reg;
  logic [CNT_W-1:0]   stall_reg;

  logic               any_block;
  logic [IDX_W-1:0]   low_idx;
  logic [CNT_W-1:0]   teff;
  logic [CNT_W-1:0]   stall_next;

  assign any_block  = |mon_block;
  // A zero threshold behaves as a one-cycle threshold.
  assign teff       = (threshold == '0) ? CNT_W'(1) : threshold;
  assign stall_next = (stall_reg == {CNT_W{1'b1}}) ? stall_reg : stall_reg + CNT_W'(1);

  // Descending scan so the lowest set bit wins.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (mon_block[i]) low_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      valid_reg <= 1'b0;
      irq_reg   <= 1'b0;
      idx_reg   <= '0;
      mask_reg  <= '0;
      stall_reg <= '0;
    end else if (clear) begin
      state_reg <= S_IDLE;
      valid_reg <= 1'b0;
      irq_reg   <= 1'b0;
      idx_reg   <= '0;
      mask_reg  <= '0;
      stall_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (enable && any_block) begin
            idx_reg   <= low_idx;
            mask_reg  <= mon_block;
            stall_reg <= CNT_W'(1);
            if (teff == CNT_W'(1)) begin
              state_reg <= S_REPORT;
              valid_reg <= 1'b1;
              irq_reg   <= 1'b1;
            end else begin
              state_reg <= S_COUNT;
            end
          end else begin
            stall_reg <= '0;
          end
        end
        S_COUNT: begin
          if (!any_block || !enable) begin
            state_reg <= S_IDLE;
            stall_reg <= '0;
            mask_reg  <= '0;
          end else begin
            mask_reg  <= mask_reg | mon_block;
            stall_reg <= stall_next;
            if (stall_next >= teff) begin
              state_reg <= S_REPORT;
              valid_reg <= 1'b1;
              irq_reg   <= 1'b1;
            end
          end
        end
        S_REPORT: begin
          if (any_block) stall_reg <= stall_next;
          if (report_ready) begin
            state_reg <= S_LATCHED;
            valid_reg <= 1'b0;
          end
        end
        default: begin
          if (any_block) stall_reg <= stall_next;
        end
      endcase
    end
  end

  assign report_valid = valid_reg;
  assign deadlock_irq = irq_reg;
  assign report_idx   = idx_reg;
  assign report_mask  = mask_reg;
  assign stall_cycles = stall_reg;
  assign state        = state_reg;

endmodule

// File: tb/tb_linearb_deadlock_watchdog.sv
// Directed bench for linearb_deadlock_watchdog: persistence, transient, offender/mask,
// handshake backpressure, clear priority, async reset and counter saturation.
module tb_linearb_deadlock_watchdog;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  mon_block = '0;
  logic        enable = 1'b0;
  logic [15:0] threshold = '0;
  logic        clear = 1'b0;
  logic        report_ready = 1'b0;
  logic        report_valid;
  logic [1:0]  report_idx;
  logic [3:0]  report_mask;
  logic [15:0] stall_cycles;
  logic        deadlock_irq;
  logic [1:0]  state;

  logic [3:0]  sat_mon = '0;
  logic [3:0]  sat_threshold = '0;
  logic        sat_valid;
  logic [1:0]  sat_idx;
  logic [3:0]  sat_mask;
  logic [3:0]  sat_stall;
  logic        sat_irq;
  logic [1:0]  sat_state;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  linearb_deadlock_watchdog #(.NUM_MON(4), .IDX_W(2), .CNT_W(16)) u_dut (
    .clock(clock), .reset_n(reset_n), .mon_block(mon_block), .enable(enable),
    .threshold(threshold), .clear(clear), .report_valid(report_valid),
    .report_ready(report_ready), .report_idx(report_idx), .report_mask(report_mask),
    .stall_cycles(stall_cycles), .deadlock_irq(deadlock_irq), .state(state)
  );

  linearb_deadlock_watchdog #(.NUM_MON(4), .IDX_W(2), .CNT_W(4)) u_sat (
    .clock(clock), .reset_n(reset_n), .mon_block(sat_mon), .enable(enable),
    .threshold(sat_threshold), .clear(clear), .report_valid(sat_valid),
    .report_ready(1'b0), .report_idx(sat_idx), .report_mask(sat_mask),
    .stall_cycles(sat_stall), .deadlock_irq(sat_irq), .state(sat_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic v, input logic irq,
                           input logic [1:0] idx, input logic [3:0] mask, input logic [15:0] stall);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".valid"}, 32'(report_valid), 32'(v));
    check({tag, ".irq"}, 32'(deadlock_irq), 32'(irq));
    check({tag, ".idx"}, 32'(report_idx), 32'(idx));
    check({tag, ".mask"}, 32'(report_mask), 32'(mask));
    check({tag, ".stall"}, 32'(stall_cycles), 32'(stall));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #2;
    check_all("reset", 2'd0, 1'b0, 1'b0, 2'd0, 4'h0, 16'd0);
    check("reset.sat_stall", 32'(sat_stall), 32'd0);
    tick(1);
    reset_n = 1'b1;
    enable = 1'b1;
    tick(2);
    check_all("idle", 2'd0, 1'b0, 1'b0, 2'd0, 4'h0, 16'd0);

    // Persistent block, Teff=4
    threshold = 16'd4;
    mon_block = 4'b0100;
    tick(1);
    check_all("persist.e0", 2'd1, 1'b0, 1'b0, 2'd2, 4'b0100, 16'd1);
    tick(1);
    check_all("persist.e1", 2'd1, 1'b0, 1'b0, 2'd2, 4'b0100, 16'd2);
    tick(1);
    check_all("persist.e2", 2'd1, 1'b0, 1'b0, 2'd2, 4'b0100, 16'd3);
    tick(1);
    check_all("persist.trip", 2'd2, 1'b1, 1'b1, 2'd2, 4'b0100, 16'd4);
    mon_block = 4'b0000;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check_all("persist.clear", 2'd0, 1'b0, 1'b0, 2'd0, 4'h0, 16'd0);

    // Transient stall, 3 cycles
    mon_block = 4'b0001;
    tick(3);
    check_all("transient.count", 2'd1, 1'b0, 1'b0, 2'd0, 4'b0001, 16'd3);
    mon_block = 4'b0000;
    tick(1);
    check_all("transient.drop", 2'd0, 1'b0, 1'b0, 2'd0, 4'h0, 16'd0);
    tick(3);
    check("transient.no_report", 32'(report_valid), 32'd0);

    // Threshold 0 behaves as 1
    threshold = 16'd0;
    mon_block = 4'b1010;
    tick(1);
    check_all("thr0.trip", 2'd2, 1'b1, 1'b1, 2'd1, 4'b1010, 16'd1);
    mon_block = 4'b0000;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;

    // Mask accumulation with Teff=3
    threshold = 16'd3;
    mon_block = 4'b0001;
    tick(1);
    check_all("mask.s0", 2'd1, 1'b0, 1'b0, 2'd0, 4'b0001, 16'd1);
    mon_block = 4'b1000;
    tick(1);
    check_all("mask.s1", 2'd1, 1'b0, 1'b0, 2'd0, 4'b1001, 16'd2);
    tick(1);
    check_all("mask.trip", 2'd2, 1'b1, 1'b1, 2'd0, 4'b1001, 16'd3);
    mon_block = 4'b0000;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;

    // Handshake backpressure, Teff=2
    threshold = 16'd2;
    mon_block = 4'b0010;
    tick(2);
    check_all("hs.trip", 2'd2, 1'b1, 1'b1, 2'd1, 4'b0010, 16'd2);
    mon_block = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check_all($sformatf("hs.wait%0d", i), 2'd2, 1'b1, 1'b1, 2'd1, 4'b0010, 16'd2);
    end
    report_ready = 1'b1;
    mon_block = 4'b0100;
    tick(1);
    report_ready = 1'b0;
    check_all("hs.accept", 2'd3, 1'b0, 1'b1, 2'd1, 4'b0010, 16'd3);
    tick(2);
    check_all("hs.no_second", 2'd3, 1'b0, 1'b1, 2'd1, 4'b0010, 16'd5);
    mon_block = 4'b0000;
    tick(1);
    check("hs.hold_stall", 32'(stall_cycles), 32'd5);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check_all("hs.clear", 2'd0, 1'b0, 1'b0, 2'd0, 4'h0, 16'd0);

    // Clear beats a same-edge handshake
    threshold = 16'd1;
    mon_block = 4'b0001;
    tick(1);
    check("clrpri.report", 32'(state), 32'd2);
    clear = 1'b1;
    report_ready = 1'b1;
    tick(1);
    clear = 1'b0;
    report_ready = 1'b0;
    mon_block = 4'b0000;
    check_all("clrpri.idle", 2'd0, 1'b0, 1'b0, 2'd0, 4'h0, 16'd0);

    // Clear aborts COUNT at stall 5, then a fresh count starts
    threshold = 16'd8;
    mon_block = 4'b0001;
    tick(5);
    check_all("clrcnt.count", 2'd1, 1'b0, 1'b0, 2'd0, 4'b0001, 16'd5);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check_all("clrcnt.abort", 2'd0, 1'b0, 1'b0, 2'd0, 4'h0, 16'd0);
    tick(1);
    check_all("clrcnt.rearm", 2'd1, 1'b0, 1'b0, 2'd0, 4'b0001, 16'd1);
    tick(2);
    check("clrcnt.fresh", 32'(stall_cycles), 32'd3);

    // Asynchronous reset mid-COUNT
    #2;
    reset_n = 1'b0;
    #1;
    check_all("areset", 2'd0, 1'b0, 1'b0, 2'd0, 4'h0, 16'd0);
    mon_block = 4'b0000;
    tick(1);
    reset_n = 1'b1;
    tick(1);
    check_all("areset.after", 2'd0, 1'b0, 1'b0, 2'd0, 4'h0, 16'd0);

    // Saturation with a 4-bit counter
    sat_mon = 4'b0001;
    tick(20);
    check("sat.stall", 32'(sat_stall), 32'd15);
    check("sat.state", 32'(sat_state), 32'd2);
    check("sat.valid", 32'(sat_valid), 32'd1);
    sat_mon = 4'b0000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/linearb_deadlock_watchdog.md
# lineArb_deadlock_watchdog

Deadlock watchdog and reporter for the lineArb HLS core. Collects the `block` outputs of the per-instance deadlock monitors and qualifies them with a programmable persistence threshold, so a transient stall is not reported. A qualified deadlock is latched into a sticky report record, presented once over a valid/ready handshake, and signalled on a sticky interrupt until software clears it.

## Interface

Parameters:
- `NUM_MON`, default 4: number of monitor `block` inputs; must be 2 or more.
- `IDX_W`, default 2: width of the offender index, equal to clog2(`NUM_MON`).
- `CNT_W`, default 16: width of the threshold and the stall counter.

Ports:
- `clock`, in, 1: the single clock; all logic is rising-edge.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `mon_block`, in, `NUM_MON`: per-monitor block flags. Bit i comes from monitor i.
- `enable`, in, 1: arms detection.
- `threshold`, in, `CNT_W`: number of consecutive blocked cycles required to trip. It must be held static while the block is in COUNT.
- `clear`, in, 1: single-cycle pulse. Aborts or acknowledges any state and returns the block to IDLE.
- `report_valid`, out, 1: a report is pending.
- `report_ready`, in, 1: the consumer accepts the report.
- `report_idx`, out, `IDX_W`: lowest-numbered monitor that was blocking on the first blocked cycle.
- `report_mask`, out, `NUM_MON`: OR of all `mon_block` samples from the first blocked cycle through the trip cycle.
- `stall_cycles`, out, `CNT_W`: consecutive blocked-cycle count. Saturates at all-ones.
- `deadlock_irq`, out, 1: sticky interrupt.
- `state`, out, 2: encoded state. IDLE=0, COUNT=1, REPORT=2, LATCHED=3.

## Operation

- Let `any` = OR of all bits of `mon_block`. All inputs are sampled on the rising edge of `clock`.
- The effective threshold Teff is `threshold`, except that a `threshold` of 0 is treated as 1.
- **IDLE**
  - `enable` && `any`:
    - capture `report_idx` = lowest set bit of `mon_block`;
    - set `report_mask` = `mon_block`;
    - set `stall_cycles` = 1;
    - go to REPORT if Teff == 1, otherwise go to COUNT.
  - Otherwise: hold, with `stall_cycles` = 0.
- **COUNT**
  - `!any` or `!enable`: go to IDLE; clear `stall_cycles` and `report_mask`.
  - Otherwise:
    - `report_mask` |= `mon_block`;
    - `stall_cycles` increments, saturating;
    - if the incremented value is >= Teff, go to REPORT.
- **REPORT**
  - `report_valid` = 1 and `deadlock_irq` = 1.
  - `report_idx` and `report_mask` are frozen.
  - `stall_cycles` keeps incrementing (saturating) while `any` is high, and holds while `any` is low.
  - `report_valid` && `report_ready`: go to LATCHED.
  - `enable` has no effect in this state.
- **LATCHED**
  - `report_valid` = 0; `deadlock_irq` stays at 1.
  - The record is frozen and no new report can be generated.
  - `stall_cycles` behaves as in REPORT.
- **clear** has the highest priority in every state. On the next edge:
  - state goes to IDLE;
  - `deadlock_irq`, `report_valid`, `report_idx`, `report_mask` and `stall_cycles` all go to 0.
  - This applies even when a handshake or a trip would fire on the same edge.
- **Simultaneous events:**
  - A trip and `!any` cannot coincide, because a trip requires `any`.
  - A handshake in the same cycle that `mon_block` changes: the record stays frozen.
- **Arithmetic:** all comparisons are unsigned at `CNT_W` bits. The saturation value is 2^`CNT_W`−1.

## Timing

- **Reset value of every output is 0**, asserted asynchronously. Reset may hit mid-COUNT or mid-REPORT; the block then leaves reset in IDLE with no report pending.
- Deassertion of `reset_n` must be synchronised externally to `clock`.
- All outputs are registered. There is no combinational path from any input to any output.
- **Trip latency:** when `mon_block` is first sampled high at edge k and stays high, `report_valid` and `deadlock_irq` rise after edge k+Teff−1.
- **Handshake:**
  - `report_valid` does not depend on `report_ready`.
  - `report_valid` stays high until the edge at which `report_ready` is sampled high.
  - It falls after that edge.
- **Clear latency:** one cycle. `clear` sampled at edge c gives IDLE and cleared outputs after edge c.
- Re-arming after clear: a new blocked sample at edge c+1 starts a fresh count.

## Test plan

- **Persistent block:** Teff=4; hold `mon_block`=0b0100 from edge 10.
  - `state` = COUNT at edges 10–12.
  - `report_valid` and `deadlock_irq` = 1 after edge 13.
  - `report_idx`=2, `report_mask`=0b0100, `stall_cycles`=4.
- **Transient stall:** Teff=4; assert `mon_block`=0b0001 for 3 cycles, then 0.
  - No report; `state` returns to IDLE.
  - `stall_cycles`=0 and `report_mask`=0 after the drop.
- **Offender, mask and threshold 0:** `threshold`=0.
  - First blocked sample `mon_block`=0b1010 gives REPORT after 1 cycle, `report_idx`=1, `report_mask`=0b1010.
  - With Teff=3 and samples 0b0001, 0b1000, 0b1000: `report_idx`=0, `report_mask`=0b1001.
- **Handshake backpressure:** hold `report_ready`=0 for 5 cycles after a trip, then raise it.
  - `report_valid` stays high for those 5 cycles and drops after the accept edge.
  - `state`=LATCHED; `deadlock_irq` stays 1.
  - A later new block produces no second report.
- **Clear priority:** in REPORT, assert `clear` and `report_ready` on the same edge.
  - Next cycle: `state`=IDLE and every output is 0.
  - Assert `clear` in COUNT with Teff=8 at `stall_cycles`=5: the block aborts to IDLE and no report is produced.
- **Async reset and saturation:**
  - Drop `reset_n` mid-COUNT: all outputs go to 0 immediately, without waiting for a clock edge.
  - With `CNT_W`=4, block for 20 cycles: `stall_cycles` saturates at 15.
